// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sequential load/store front end for a word-wide data memory. Accepts one
//   CPU request at a time, supports byte/half/word access with signed or
//   unsigned load extension, and performs sub-word stores as a read-modify-
//   write because the memory only writes whole words. Lanes are little-endian.
//
// Ports
//   clk, rst       : clock (memory writes on negedge), sync active-high reset
//   req_valid      : request strobe, sampled only while req_ready=1
//   req_ready      : high only when idle
//   req_we         : 1 = store, 0 = load
//   req_size       : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned   : zero-extend loads when 1, sign-extend when 0
//   req_addr       : byte address
//   req_wdata      : right-aligned store data
//   resp_valid     : one-cycle completion pulse
//   resp_err       : misaligned address or reserved size, valid with resp_valid
//   resp_rdata     : extended load result, held until the next load completes
//   mem_wen/ren    : memory write / read enables
//   mem_addr       : word-aligned memory address
//   mem_data_i     : full word written to memory
//   mem_data_o     : combinational memory read data for mem_addr
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_i,
    input  logic [31:0] mem_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_LD, S_STW, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_rdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;

    logic        w_req_err;
    logic [31:0] w_word_addr;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] f_load_ext(input logic [31:0] w,
                                               input logic [1:0]  ofs,
                                               input logic [1:0]  sz,
                                               input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (ofs)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = ofs[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or half of the captured word with store data.
    function automatic logic [31:0] f_merge(input logic [31:0] w,
                                            input logic [31:0] wd,
                                            input logic [1:0]  ofs,
                                            input logic [1:0]  sz);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (ofs)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (ofs[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        return r;
    endfunction

    always_comb begin
        w_req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merge      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_ready <= 1'b0;
                        if (w_req_err)
                            r_state <= S_ERR;
                        else if (!req_we)
                            r_state <= S_LD;
                        else if (req_size == 2'b10)
                            r_state <= S_STW;
                        else
                            r_state <= S_RMW_RD;
                    end
                end
                S_ERR: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end
                S_LD: begin
                    r_rdata      <= f_load_ext(mem_data_o, r_addr[1:0], r_size, r_uns);
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_STW: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_RMW_RD: begin
                    r_merge <= mem_data_o;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Memory controls come only from registered state and latched fields, so
    // they are stable for the whole cycle ahead of the memory's negedge write.
    always_comb begin
        w_word_addr = {r_addr[31:2], 2'b00};
        mem_wen     = (r_state == S_STW) || (r_state == S_RMW_WR);
        mem_ren     = (r_state == S_LD)  || (r_state == S_RMW_RD);
        mem_addr    = (mem_wen || mem_ren) ? w_word_addr : 32'h0;
        mem_data_i  = 32'h0;
        if (r_state == S_STW)
            mem_data_i = r_wdata;
        else if (r_state == S_RMW_WR)
            mem_data_i = f_merge(r_merge, r_wdata, r_addr[1:0], r_size);
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
    );

    // Word memory model: combinational read, negedge write, plus a preload port.
    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    always @(negedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (mem_wen)
            mem[mem_addr[11:2]] <= mem_data_i;
    end
    assign mem_data_o = mem[mem_addr[11:2]];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_idx  = a[11:2];
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    task automatic push_exp(input logic err, input logic is_load,
                            input logic [31:0] rd, input int lat);
        exp_t e;
        e.err   = err;
        e.rdata = (is_load && !err) ? rd : last_rdata;
        e.lat   = lat;
        if (is_load && !err)
            last_rdata = rd;
        sb_q.push_back(e);
    endtask

    // Present one request; returns at the negedge of cycle 1 with inputs scrambled.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", {31'b0, req_ready}, 32'h1);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        cyc          = 1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom();
        req_wdata    = $urandom();
        chk("busy_c1", {31'b0, req_ready}, 32'h0);
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        while (resp_valid !== 1'b1 && cyc < 12)
            tick();
        e = sb_q.pop_front();
        chk({tag, "_valid"}, {31'b0, resp_valid}, 32'h1);
        chk({tag, "_lat"}, cyc, e.lat);
        chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_mem_idle"}, {30'b0, mem_wen, mem_ren}, 32'h0);
        chk({tag, "_busy_resp"}, {31'b0, req_ready}, 32'h0);
        tick();
        chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'h0);
        chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'h1);
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp);
        push_exp(1'b0, 1'b1, exp, 2);
        send(1'b0, sz, uns, a, $urandom());
        chk({tag, "_ren"}, {30'b0, mem_ren, mem_wen}, 32'h2);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        wait_resp(tag);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [1:0] sz,
                          input logic [31:0] a);
        push_exp(1'b1, ~we, 32'h0, 2);
        send(we, sz, 1'b0, a, $urandom());
        chk({tag, "_noacc_c1"}, {30'b0, mem_wen, mem_ren}, 32'h0);
        chk({tag, "_addr0_c1"}, mem_addr, 32'h0);
        tick();
        chk({tag, "_noacc_c2"}, {30'b0, mem_wen, mem_ren}, 32'h0);
        wait_resp(tag);
    endtask

    task automatic do_rmw(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] merged);
        push_exp(1'b0, 1'b0, 32'h0, 3);
        send(1'b1, sz, 1'b0, a, wd);
        chk({tag, "_c1_rd"}, {30'b0, mem_ren, mem_wen}, 32'h2);
        chk({tag, "_c1_addr"}, mem_addr, {a[31:2], 2'b00});
        tick();
        chk({tag, "_c2_wr"}, {30'b0, mem_ren, mem_wen}, 32'h1);
        chk({tag, "_c2_data"}, mem_data_i, merged);
        chk({tag, "_c2_addr"}, mem_addr, {a[31:2], 2'b00});
        wait_resp(tag);
        #1;
        chk({tag, "_memword"}, mem[a[11:2]], merged);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_ctl", {30'b0, mem_wen, mem_ren}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data", mem_data_i, 32'h0);

        // Reset wins over a simultaneous request
        preload(32'h100, 32'h80FF_1234);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h100; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        chk("rstprio_ready", {31'b0, req_ready}, 32'h1);
        chk("rstprio_noren", {31'b0, mem_ren}, 32'h0);
        @(negedge clk);
        chk("rstprio_idle", {30'b0, mem_ren, resp_valid}, 32'h0);

        // Loads from 0x80FF_1234
        do_load("lb103",  2'b00, 1'b0, 32'h103, 32'hFFFF_FF80);
        do_load("lbu103", 2'b00, 1'b1, 32'h103, 32'h0000_0080);
        do_load("lh100",  2'b01, 1'b0, 32'h100, 32'h0000_1234);
        do_load("lh102",  2'b01, 1'b0, 32'h102, 32'hFFFF_80FF);
        do_load("lhu102", 2'b01, 1'b1, 32'h102, 32'h0000_80FF);
        do_load("lbu102", 2'b00, 1'b1, 32'h102, 32'h0000_00FF);
        do_load("lb101",  2'b00, 1'b0, 32'h101, 32'h0000_0012);
        do_load("lw100",  2'b10, 1'b0, 32'h100, 32'h80FF_1234);

        // Sub-word stores by read-modify-write
        preload(32'h100, 32'h1122_3344);
        do_rmw("sh102", 2'b01, 32'h102, 32'h1234_BEEF, 32'hBEEF_3344);
        do_rmw("sb101", 2'b00, 32'h101, 32'hFFFF_FFAA, 32'hBEEF_AA44);
        do_load("lw_after_rmw", 2'b10, 1'b1, 32'h100, 32'hBEEF_AA44);

        // Error requests: no memory access, rdata held
        do_err("err_lw6",  1'b0, 2'b10, 32'h0000_0006);
        do_err("err_sh3",  1'b1, 2'b01, 32'h0000_0003);
        do_err("err_rsvd", 1'b0, 2'b11, 32'h0000_0100);

        // Word store followed back-to-back by a load of the same word
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h200; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        push_exp(1'b0, 1'b0, 32'h0, 2);
        @(negedge clk);
        cyc = 1;
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200; req_wdata = 32'h0;
        chk("b2b_stw_wen", {30'b0, mem_wen, mem_ren}, 32'h2);
        chk("b2b_stw_data", mem_data_i, 32'hDEAD_BEEF);
        chk("b2b_stw_addr", mem_addr, 32'h200);
        chk("b2b_stall_c1", {31'b0, req_ready}, 32'h0);
        tick();
        wait_resp("b2b_sw");
        push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, 2);
        tick();
        cyc = 1;
        chk("b2b_ld_ren", {30'b0, mem_ren, mem_wen}, 32'h2);
        chk("b2b_ld_addr", mem_addr, 32'h200);
        req_addr = 32'h100;
        tick();
        req_valid = 1'b0;
        wait_resp("b2b_lw");
        for (int i = 0; i < 4; i++) begin
            chk("b2b_no_extra", {30'b0, resp_valid, mem_ren}, 32'h0);
            tick();
        end

        // Reset during RMW_RD aborts the byte store
        preload(32'h100, 32'h1122_3344);
        send(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_0055);
        chk("rmwrst_c1_ren", {31'b0, mem_ren}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rdata = 32'h0;
        chk("rmwrst_ready", {31'b0, req_ready}, 32'h1);
        chk("rmwrst_ctl", {28'b0, mem_wen, mem_ren, resp_valid, resp_err}, 32'h0);
        chk("rmwrst_addr", mem_addr, 32'h0);
        chk("rmwrst_data", mem_data_i, 32'h0);
        chk("rmwrst_rdata", resp_rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rmwrst_quiet", {30'b0, resp_valid, mem_wen}, 32'h0);
            tick();
        end
        #1;
        chk("rmwrst_memword", mem[64], 32'h1122_3344);
        do_load("lw_after_rst", 2'b10, 1'b0, 32'h100, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store front end placed directly upstream of the word-wide data memory. It accepts one CPU memory request at a time and supports byte, halfword and word access, with signed or unsigned load extension. Sub-word stores are done as a read-modify-write, because the data memory only writes whole words. The unit drives the memory's `mem_wen`/`mem_ren`/`mem_addr`/`mem_data_i` and consumes its combinational `mem_data_o`.

## Interface
- No parameters; data and address paths are fixed at 32 bits.
- `clk` in 1 — system clock. The data memory writes on `negedge clk`; this unit updates on `posedge clk`.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — request strobe, sampled only when `req_ready`=1.
- `req_ready` out 1 — high only in IDLE.
- `req_we` in 1 — 1 = store, 0 = load.
- `req_size` in 2 — 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1 — load zero-extends when 1 and sign-extends when 0; ignored for stores.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1 — one-cycle completion pulse.
- `resp_err` out 1 — valid with `resp_valid`; signals a misaligned address or reserved size.
- `resp_rdata` out 32 — extended load result; held until the next load completes.
- `mem_wen` out 1 — memory write enable.
- `mem_ren` out 1 — memory read enable.
- `mem_addr` out 32 — word address, `{req_addr[31:2],2'b00}`.
- `mem_data_i` out 32 — full word written to memory.
- `mem_data_o` in 32 — memory read data, combinational from `mem_addr`.

## Operation
- **Byte lanes** are little-endian:
  - `addr[1:0]`=0..3 selects bits [7:0], [15:8], [23:16], [31:24].
  - `addr[1]`=0/1 selects half [15:0] / [31:16].
- **Request latch:** on acceptance, the unit latches `we`, `size`, `unsigned`, `addr` and `wdata` into internal registers. Request inputs are don't-care after that.
- **Error check:** a request is an error if either of these holds:
  - `size`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - An error request makes no memory access.
- **FSM states:**
  - IDLE → ERR on an error request.
  - IDLE → LD on a load.
  - IDLE → STW on a word store.
  - IDLE → RMW_RD on a byte or half store.
  - ERR → RESP.
  - LD: `mem_ren`=1; register the extracted and extended lane of `mem_data_o` into `resp_rdata`; → RESP.
  - STW: `mem_wen`=1, `mem_data_i`=`wdata`; → RESP.
  - RMW_RD: `mem_ren`=1; capture `mem_data_o` into a merge register; → RMW_WR.
  - RMW_WR: `mem_wen`=1; `mem_data_i` = captured word with the selected lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`; → RESP.
  - RESP: `resp_valid`=1, `resp_err` set if the request came from ERR; → IDLE.
- **Output decoding:** `mem_wen`, `mem_ren`, `mem_addr` and `mem_data_i` are decoded only from registered state and latched fields. They are stable for the whole cycle, so the negedge write sees clean values.
- **Idle outputs:** outside LD, STW, RMW_RD and RMW_WR, `mem_wen`=`mem_ren`=0 and `mem_addr`=`mem_data_i`=0.
- **Stores:** `resp_rdata` is unchanged by stores and by errors.

## Timing
- **Latency:** cycle 0 is the acceptance edge.
  - Load: LD in cycle 1, `resp_valid` in cycle 2.
  - Word store: STW in cycle 1 (memory written at the cycle-1 negedge), `resp_valid` in cycle 2.
  - Sub-word store: RMW_RD in cycle 1, RMW_WR in cycle 2, `resp_valid` in cycle 3.
  - Error: `resp_valid`+`resp_err` in cycle 2.
- **Back-to-back:** the next request can be accepted in the cycle after RESP. `req_ready`=0 from acceptance through RESP inclusive; `req_valid` during busy cycles is ignored, not queued.
- **Reset values:** at the `posedge` with `rst`=1:
  - state=IDLE.
  - `req_ready`=1 after reset.
  - All other outputs and internal registers are 0, including `resp_rdata`=0.
- **Reset mid-operation:**
  - During LD, RMW_RD or ERR: the operation aborts, no write occurs, and no `resp_valid` is issued.
  - During STW or RMW_WR: the write has already happened at that cycle's negedge before the reset edge. It is not undone, and no `resp_valid` is issued.
- **Reset priority:** if `rst` and `req_valid` are asserted together, `rst` wins and the request is dropped.

## Test plan
- Memory word 0x0000_0100 = 0x80FF_1234:
  - lb @0x103 → `resp_rdata`=0xFFFF_FF80 in cycle 2.
  - lbu @0x103 → 0x0000_0080.
  - lh @0x100 → 0x0000_1234.
  - lh @0x102 → 0xFFFF_80FF.
- Word 0x0000_0100 = 0x1122_3344: sh 0xBEEF @0x102 → word becomes 0xBEEF_3344. `mem_ren` asserted in cycle 1, `mem_wen` in cycle 2, `resp_valid` in cycle 3. Then sb 0xAA @0x101 → 0xBEEF_AA44.
- lw @0x0000_0006 and sh @0x0000_0003 → each `resp_valid`=1, `resp_err`=1 in cycle 2. `mem_ren`=`mem_wen`=0 throughout; `resp_rdata` unchanged.
- sw 0xDEAD_BEEF @0x200, then lw @0x200 presented back-to-back → second request is stalled (`req_ready`=0) until after RESP, then returns 0xDEAD_BEEF. `req_valid` pulsed while busy produces no extra response.
- sb 0x55 @0x101 onto word 0x1122_3344 with `rst` asserted during RMW_RD → word stays 0x1122_3344, no `resp_valid`, all outputs 0 and `req_ready`=1 after reset.
